// File: rtl/mem_traffic_gen.sv
// Programmable read/write request generator for the cache memory system.
// Issues LFSR-driven requests in four address patterns and gathers statistics.
module mem_traffic_gen #(
  parameter int          NUM_REQ = 1000,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        Stall,
  input  logic        Done,
  input  logic        CacheHit,
  output logic [15:0] Addr,
  output logic [15:0] DataIn,
  output logic        Rd,
  output logic        Wr,
  output logic        busy,
  output logic        finished,
  output logic [15:0] n_reqs,
  output logic [15:0] n_hits,
  output logic        lat_err,
  output logic        drop_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECIDE,
    S_WAIT,
    S_FINISH
  } state_e;

  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT);
  localparam logic [16:0] REQ_LIM = 17'(NUM_REQ);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  idx_q, idx_d;
  logic [4:0]  tag_q, tag_d;
  logic        phase_q, phase_d;
  logic [15:0] lat_q, lat_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        fin_q, fin_d;
  logic [15:0] nreq_q, nreq_d;
  logic [15:0] nhit_q, nhit_d;
  logic        lerr_q, lerr_d;
  logic        derr_q, derr_d;

  logic [15:0] lfsr_nx;
  logic [15:0] rswap;
  logic [7:0]  idx_inc;
  logic [4:0]  tag_inc;

  always_comb begin
    lfsr_nx = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    rswap   = {lfsr_nx[7:0], lfsr_nx[15:8]};
    idx_inc = (idx_q < 8'd8) ? idx_q + 8'd1 : 8'd0;
    tag_inc = tag_q + 5'd1;

    state_d = state_q;
    mode_d  = mode_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    phase_d = phase_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    nreq_d  = nreq_q;
    nhit_d  = nhit_q;
    lerr_d  = lerr_q;
    derr_d  = derr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          nreq_d  = '0;
          nhit_d  = '0;
          lerr_d  = 1'b0;
          derr_d  = 1'b0;
          idx_d   = '0;
          tag_d   = '0;
          phase_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        lfsr_d = lfsr_nx;
        if (!Stall && lfsr_nx[0]) begin
          wr_d    = lfsr_nx[1];
          rd_d    = ~lfsr_nx[1];
          data_d  = lfsr_nx;
          lat_d   = 16'd1;
          state_d = S_WAIT;
          unique case (mode_q)
            2'd0: addr_d = rswap & 16'hFFFE;
            2'd1: addr_d = (rswap & 16'h07FE) | 16'h6000;
            2'd2: begin
              idx_d  = idx_inc;
              addr_d = {5'd0, idx_inc, 3'b000};
            end
            default: begin
              phase_d = ~phase_q;
              // set advances on the first request of each pair
              if (!phase_q) begin
                idx_d  = idx_inc;
                tag_d  = idx_inc[4:0];
                addr_d = {idx_inc[4:0], idx_inc, 3'b000};
              end else begin
                tag_d  = tag_inc;
                addr_d = {tag_inc, idx_q, 3'b000};
              end
            end
          endcase
        end
      end
      S_WAIT: begin
        if (Done || lat_q >= TO_LIM) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (nreq_q != 16'hFFFF) nreq_d = nreq_q + 16'd1;
          if (Done) begin
            if (CacheHit && nhit_q != 16'hFFFF) nhit_d = nhit_q + 16'd1;
            if (CacheHit && lat_q > 16'd2) lerr_d = 1'b1;
            if (!CacheHit && (lat_q <= 16'd2 || lat_q > 16'd20))
              lerr_d = 1'b1;
          end else begin
            derr_d = 1'b1;
          end
          if ({1'b0, nreq_q} + 17'd1 == REQ_LIM) begin
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_DECIDE;
          end
        end else begin
          lat_d = lat_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      tag_q   <= '0;
      phase_q <= 1'b0;
      lat_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      nreq_q  <= '0;
      nhit_q  <= '0;
      lerr_q  <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      phase_q <= phase_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      nreq_q  <= nreq_d;
      nhit_q  <= nhit_d;
      lerr_q  <= lerr_d;
      derr_q  <= derr_d;
    end
  end

  assign Addr     = addr_q;
  assign DataIn   = data_q;
  assign Rd       = rd_q;
  assign Wr       = wr_q;
  assign busy     = busy_q;
  assign finished = fin_q;
  assign n_reqs   = nreq_q;
  assign n_hits   = nhit_q;
  assign lat_err  = lerr_q;
  assign drop_err = derr_q;

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Bench for mem_traffic_gen: a memory responder model with a scoreboard
// of expected request addresses.
module tb_mem_traffic_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        Stall;
  logic        Done;
  logic        CacheHit;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        busy;
  logic        finished;
  logic [15:0] n_reqs;
  logic [15:0] n_hits;
  logic        lat_err;
  logic        drop_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mem_traffic_gen #(
    .NUM_REQ(4),
    .SEED   (16'hACE1),
    .TIMEOUT(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .Stall   (Stall),
    .Done    (Done),
    .CacheHit(CacheHit),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .Rd      (Rd),
    .Wr      (Wr),
    .busy    (busy),
    .finished(finished),
    .n_reqs  (n_reqs),
    .n_hits  (n_hits),
    .lat_err (lat_err),
    .drop_err(drop_err)
  );

  task automatic start_run(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!(Rd | Wr) && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = Rd | Wr;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_wait: no request within %0d cycles", n);
    end
  endtask

  // chk: 0 none, 1 small-random pattern, 2 full-random pattern
  task automatic serve(input int lat, input bit hit, input int chk);
    bit ok;
    logic [15:0] e;
    logic [15:0] r;
    wait_req(ok);
    if (!ok) return;
    r = {DataIn[7:0], DataIn[15:8]};
    n_tests++;
    if (Rd === Wr) begin
      n_fail++;
      $display("FAIL rd_wr_excl: Rd=%b Wr=%b", Rd, Wr);
    end
    n_tests++;
    if (Wr !== DataIn[1] || DataIn[0] !== 1'b1 || Addr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL req_fields: Wr=%b DataIn=%h Addr=%h", Wr, DataIn, Addr);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (Addr !== e) begin
        n_fail++;
        $display("FAIL addr_seq: got %h want %h", Addr, e);
      end
    end
    if (chk == 1) begin
      e = (r & 16'h07FE) | 16'h6000;
      n_tests++;
      if (Addr !== e || Addr[15:11] !== 5'b01100) begin
        n_fail++;
        $display("FAIL addr_mode1: got %h want %h", Addr, e);
      end
    end
    if (chk == 2) begin
      e = r & 16'hFFFE;
      n_tests++;
      if (Addr !== e) begin
        n_fail++;
        $display("FAIL addr_mode0: got %h want %h", Addr, e);
      end
    end
    repeat (lat - 1) @(negedge clk);
    Done     = 1'b1;
    CacheHit = hit;
    @(negedge clk);
    Done     = 1'b0;
    CacheHit = 1'b0;
    n_tests++;
    if ((Rd | Wr) !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_wr_drop: Rd=%b Wr=%b want 0", Rd, Wr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if ({Addr, DataIn, Rd, Wr, busy, finished, n_reqs, n_hits,
           lat_err, drop_err} !== 70'd0) begin
        n_fail++;
        $display("FAIL reset_outs: cycle %0d Addr=%h busy=%b n_reqs=%h",
                 i, Addr, busy, n_reqs);
      end
    end
    Done     = 1'b1;
    CacheHit = 1'b1;
    @(negedge clk);
    Done     = 1'b0;
    CacheHit = 1'b0;
    @(negedge clk);
    n_tests++;
    if (n_reqs !== 16'd0 || n_hits !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done: n_reqs=%h n_hits=%h want 0", n_reqs, n_hits);
    end
  endtask

  task automatic test_sequential;
    start_run(2'd2);
    exp_q.push_back(16'h0008);
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0018);
    exp_q.push_back(16'h0020);
    repeat (4) serve(1, 1'b1, 0);
    n_tests++;
    if (finished !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_finish: finished=%b busy=%b want 1/0", finished, busy);
    end
    n_tests++;
    if (n_reqs !== 16'd4 || n_hits !== 16'd4 || lat_err !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_stats: n_reqs=%0d n_hits=%0d lat_err=%b want 4/4/0",
               n_reqs, n_hits, lat_err);
    end
    @(negedge clk);
    n_tests++;
    if (finished !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL seq_pulse: finished=%b left=%0d want 0/0",
               finished, exp_q.size());
    end
  endtask

  task automatic test_two_sets;
    start_run(2'd3);
    exp_q.push_back(16'h0808);
    exp_q.push_back(16'h1008);
    exp_q.push_back(16'h1010);
    exp_q.push_back(16'h1810);
    repeat (4) serve(1, 1'b1, 0);
    n_tests++;
    if (n_reqs !== 16'd4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sets_done: n_reqs=%0d left=%0d want 4/0",
               n_reqs, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_latency;
    start_run(2'd2);
    serve(2, 1'b0, 0);
    n_tests++;
    if (lat_err !== 1'b1 || n_hits !== 16'd0) begin
      n_fail++;
      $display("FAIL lat_miss2: lat_err=%b n_hits=%0d want 1/0", lat_err, n_hits);
    end
    serve(3, 1'b1, 0);
    n_tests++;
    if (lat_err !== 1'b1 || n_hits !== 16'd1) begin
      n_fail++;
      $display("FAIL lat_hit3: lat_err=%b n_hits=%0d want 1/1", lat_err, n_hits);
    end
    repeat (2) serve(1, 1'b1, 0);
    n_tests++;
    if (n_hits !== 16'd3 || n_reqs !== 16'd4 || lat_err !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_final: n_hits=%0d n_reqs=%0d lat_err=%b want 3/4/1",
               n_hits, n_reqs, lat_err);
    end
    @(negedge clk);
  endtask

  task automatic test_lat_bounds;
    start_run(2'd2);
    serve(3, 1'b0, 0);
    n_tests++;
    if (lat_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_miss3: lat_err=%b want 0", lat_err);
    end
    serve(2, 1'b1, 0);
    n_tests++;
    if (lat_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_hit2: lat_err=%b want 0", lat_err);
    end
    serve(20, 1'b0, 0);
    n_tests++;
    if (lat_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_miss20: lat_err=%b want 0", lat_err);
    end
    serve(21, 1'b0, 0);
    n_tests++;
    if (lat_err !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_miss21: lat_err=%b want 1", lat_err);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit ok;
    int cnt = 0;
    start_run(2'd2);
    exp_q.push_back(16'h0008);
    wait_req(ok);
    if (ok) begin
      n_tests++;
      if (Addr !== exp_q[0]) begin
        n_fail++;
        $display("FAIL to_addr: got %h want %h", Addr, exp_q[0]);
      end
      void'(exp_q.pop_front());
      while ((Rd | Wr) && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      n_tests++;
      if (cnt != 32) begin
        n_fail++;
        $display("FAIL to_cycles: got %0d want 32", cnt);
      end
      n_tests++;
      if (drop_err !== 1'b1 || n_reqs !== 16'd1 || n_hits !== 16'd0) begin
        n_fail++;
        $display("FAIL to_stats: drop_err=%b n_reqs=%0d n_hits=%0d want 1/1/0",
                 drop_err, n_reqs, n_hits);
      end
    end
    repeat (3) serve(1, 1'b1, 0);
    n_tests++;
    if (n_reqs !== 16'd4 || n_hits !== 16'd3 || drop_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_final: n_reqs=%0d n_hits=%0d drop_err=%b want 4/3/1",
               n_reqs, n_hits, drop_err);
    end
    @(negedge clk);
    start_run(2'd2);
    serve(32, 1'b0, 0);
    n_tests++;
    if (drop_err !== 1'b0 || n_reqs !== 16'd1 || lat_err !== 1'b1) begin
      n_fail++;
      $display("FAIL done_at_to: drop_err=%b n_reqs=%0d lat_err=%b want 0/1/1",
               drop_err, n_reqs, lat_err);
    end
    repeat (3) serve(1, 1'b1, 0);
    @(negedge clk);
  endtask

  task automatic test_stall;
    Stall = 1'b1;
    start_run(2'd1);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ((Rd | Wr) !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d Rd=%b Wr=%b busy=%b", i, Rd, Wr, busy);
      end
      @(negedge clk);
    end
    Stall = 1'b0;
    repeat (4) serve(1, 1'b1, 1);
    n_tests++;
    if (n_reqs !== 16'd4) begin
      n_fail++;
      $display("FAIL stall_final: n_reqs=%0d want 4", n_reqs);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    bit ok;
    logic [15:0] e;
    start_run(2'd0);
    wait_req(ok);
    if (ok) begin
      e = {DataIn[7:0], DataIn[15:8]} & 16'hFFFE;
      n_tests++;
      if (Addr !== e) begin
        n_fail++;
        $display("FAIL addr_mode0: got %h want %h", Addr, e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({Addr, DataIn, Rd, Wr, busy, finished, n_reqs, n_hits,
         lat_err, drop_err} !== 70'd0) begin
      n_fail++;
      $display("FAIL rst_mid: Addr=%h Rd=%b Wr=%b busy=%b", Addr, Rd, Wr, busy);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if ((Rd | Wr | busy) !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: Rd=%b Wr=%b busy=%b want 0", Rd, Wr, busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 2'd0;
    Stall    = 1'b0;
    Done     = 1'b0;
    CacheHit = 1'b0;
    test_reset();
    test_sequential();
    test_two_sets();
    test_latency();
    test_lat_bounds();
    test_timeout();
    test_stall();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
